// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default widths/latencies and the opcode constants the decoder also uses.
package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } hz_state_e;

    localparam int REG_AW_DEF  = 5;
    localparam int MUL_LAT_DEF = 4;

    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] FN_MUL      = 6'h02;

endpackage

// File: rtl/hazard_detect.sv
// Combinational register-index comparator: flags load-use and the two
// branch-operand hazards (producer in EX, load in MEM). $0 never matches.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              ID_Branch,
    input  logic              ID_JumpReg,
    input  logic              EX_MemRead,
    input  logic              EX_RegWrite,
    input  logic [REG_AW-1:0] EX_WriteAddr,
    input  logic              MEM_MemRead,
    input  logic [REG_AW-1:0] MEM_WriteAddr,
    output logic              load_use,
    output logic              br_ex,
    output logic              br_mem
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_id_cmp;

    assign w_ex_hit  = (EX_WriteAddr != '0) &&
                       ((ID_UsesRs && (ID_Rs == EX_WriteAddr)) ||
                        (ID_UsesRt && (ID_Rt == EX_WriteAddr)));
    assign w_mem_hit = (MEM_WriteAddr != '0) &&
                       ((ID_UsesRs && (ID_Rs == MEM_WriteAddr)) ||
                        (ID_UsesRt && (ID_Rt == MEM_WriteAddr)));

    // Branches and jr/jalr consume operands in ID, so forwarding cannot cover them.
    assign w_id_cmp = ID_Branch || ID_JumpReg;

    assign load_use = EX_MemRead && w_ex_hit;
    assign br_ex    = w_id_cmp && EX_RegWrite && w_ex_hit;
    assign br_mem   = w_id_cmp && MEM_MemRead && w_mem_hit;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: mul hold, data stalls and
// redirects. Define HAZARD_PERF_CNT_EN to add stall/flush/mul-hold counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int REG_AW  = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              ID_Branch,
    input  logic              ID_JumpReg,
    input  logic              ID_Jump,
    input  logic              BranchTaken,
    input  logic              EX_MemRead,
    input  logic              EX_RegWrite,
    input  logic [REG_AW-1:0] EX_WriteAddr,
    input  logic              EX_MulStart,
    input  logic              MEM_MemRead,
    input  logic [REG_AW-1:0] MEM_WriteAddr,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              EX_MEM_Flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       Stall_Cycles,
    output logic [31:0]       Flush_Count,
    output logic [31:0]       MulHold_Cycles,
`endif
    output logic              Mul_Busy
);

    localparam bit         MUL_MULTI = (MUL_LAT >= 2);
    localparam logic [3:0] CNT_INIT  = MUL_MULTI ? 4'(MUL_LAT - 2) : 4'd0;

    hz_state_e   r_state;
    logic [3:0]  r_cnt;

    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;
    logic w_stall;
    logic w_redirect;
    logic w_mul_busy;
    logic w_stall_act;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_detect (
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_UsesRs     (ID_UsesRs),
        .ID_UsesRt     (ID_UsesRt),
        .ID_Branch     (ID_Branch),
        .ID_JumpReg    (ID_JumpReg),
        .EX_MemRead    (EX_MemRead),
        .EX_RegWrite   (EX_RegWrite),
        .EX_WriteAddr  (EX_WriteAddr),
        .MEM_MemRead   (MEM_MemRead),
        .MEM_WriteAddr (MEM_WriteAddr),
        .load_use      (w_load_use),
        .br_ex         (w_br_ex),
        .br_mem        (w_br_mem)
    );

    assign w_stall    = w_load_use || w_br_ex || w_br_mem;
    assign w_redirect = (ID_Branch && BranchTaken) || ID_Jump;

    // The start cycle already holds; the cnt==0 cycle is the release cycle.
    assign w_mul_busy = ((r_state == IDLE) && EX_MulStart && MUL_MULTI) ||
                        ((r_state == MUL_BUSY) && (r_cnt != 4'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (EX_MulStart && MUL_MULTI) begin
                        r_state <= MUL_BUSY;
                        r_cnt   <= CNT_INIT;
                    end
                end
                MUL_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        Mul_Busy     = 1'b0;
        w_stall_act  = 1'b0;
        if (reset) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (w_mul_busy) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
            Mul_Busy     = 1'b1;
        end else if (w_stall) begin
            // Redirect is dropped here: the branch operands are not valid yet.
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            w_stall_act = 1'b1;
        end else if (w_redirect) begin
            IF_ID_Flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic [31:0] r_mulhold_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles   <= 32'd0;
            r_flush_count    <= 32'd0;
            r_mulhold_cycles <= 32'd0;
        end else begin
            r_stall_cycles   <= r_stall_cycles + 32'(w_stall_act);
            r_flush_count    <= r_flush_count + 32'(IF_ID_Flush);
            r_mulhold_cycles <= r_mulhold_cycles + 32'(Mul_Busy);
        end
    end

    assign Stall_Cycles   = r_stall_cycles;
    assign Flush_Count    = r_flush_count;
    assign MulHold_Cycles = r_mulhold_cycles;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MUL_LAT=4); output vector order is
// {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Mul_Busy}.
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] O_DEF   = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b000100;
    localparam logic [5:0] O_REDIR = 6'b111000;
    localparam logic [5:0] O_MUL   = 6'b000011;
    localparam logic [5:0] O_RST   = 6'b001100;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_Rs, ID_Rt, EX_WriteAddr, MEM_WriteAddr;
    logic       ID_UsesRs, ID_UsesRt, ID_Branch, ID_JumpReg, ID_Jump, BranchTaken;
    logic       EX_MemRead, EX_RegWrite, EX_MulStart, MEM_MemRead;
    logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Mul_Busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Stall_Cycles, Flush_Count, MulHold_Cycles;
`endif
    logic [5:0] outs;
    int         n_checks = 0;
    int         n_fails  = 0;

    assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Mul_Busy};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MUL_LAT(4), .REG_AW(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_UsesRs     (ID_UsesRs),
        .ID_UsesRt     (ID_UsesRt),
        .ID_Branch     (ID_Branch),
        .ID_JumpReg    (ID_JumpReg),
        .ID_Jump       (ID_Jump),
        .BranchTaken   (BranchTaken),
        .EX_MemRead    (EX_MemRead),
        .EX_RegWrite   (EX_RegWrite),
        .EX_WriteAddr  (EX_WriteAddr),
        .EX_MulStart   (EX_MulStart),
        .MEM_MemRead   (MEM_MemRead),
        .MEM_WriteAddr (MEM_WriteAddr),
        .PC_Write      (PC_Write),
        .IF_ID_Write   (IF_ID_Write),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Flush   (ID_EX_Flush),
        .EX_MEM_Flush  (EX_MEM_Flush),
`ifdef HAZARD_PERF_CNT_EN
        .Stall_Cycles  (Stall_Cycles),
        .Flush_Count   (Flush_Count),
        .MulHold_Cycles(MulHold_Cycles),
`endif
        .Mul_Busy      (Mul_Busy)
    );

    task automatic clear_inputs();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        ID_Branch = 1'b0; ID_JumpReg = 1'b0; ID_Jump = 1'b0; BranchTaken = 1'b0;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteAddr = 5'd0; EX_MulStart = 1'b0;
        MEM_MemRead = 1'b0; MEM_WriteAddr = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        EX_MulStart = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_RST) begin
            n_fails++; $display("FAIL reset_outputs: got %b want %b", outs, O_RST);
        end
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== O_DEF) begin
            n_fails++; $display("FAIL post_reset_default: got %b want %b", outs, O_DEF);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_inputs();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteAddr = 5'd8;
        ID_Rs = 5'd8; ID_Rt = 5'd9; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_STALL) begin
            n_fails++; $display("FAIL load_use_rs: got %b want %b", outs, O_STALL);
        end
        next_cycle();
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteAddr = 5'd0;
        MEM_MemRead = 1'b1; MEM_WriteAddr = 5'd8;
        @(negedge clk);
        n_checks++;
        if (outs !== O_DEF) begin
            n_fails++; $display("FAIL load_use_resolved: got %b want %b", outs, O_DEF);
        end
        next_cycle();
        clear_inputs();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteAddr = 5'd12;
        ID_Rs = 5'd3; ID_Rt = 5'd12; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_STALL) begin
            n_fails++; $display("FAIL load_use_rt: got %b want %b", outs, O_STALL);
        end
        next_cycle();
        ID_UsesRt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_DEF) begin
            n_fails++; $display("FAIL load_use_unused_rt: got %b want %b", outs, O_DEF);
        end
        next_cycle();
    endtask

    task automatic test_branch_after_load();
        clear_inputs();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteAddr = 5'd9;
        ID_Rs = 5'd9; ID_Rt = 5'd0; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
        ID_Branch = 1'b1; BranchTaken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_STALL) begin
            n_fails++; $display("FAIL beq_lw_ex_stall: got %b want %b", outs, O_STALL);
        end
        next_cycle();
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteAddr = 5'd0;
        MEM_MemRead = 1'b1; MEM_WriteAddr = 5'd9;
        @(negedge clk);
        n_checks++;
        if (outs !== O_STALL) begin
            n_fails++; $display("FAIL beq_lw_mem_stall: got %b want %b", outs, O_STALL);
        end
        next_cycle();
        MEM_MemRead = 1'b0; MEM_WriteAddr = 5'd0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_REDIR) begin
            n_fails++; $display("FAIL beq_taken_redirect: got %b want %b", outs, O_REDIR);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== O_DEF) begin
            n_fails++; $display("FAIL beq_after_redirect: got %b want %b", outs, O_DEF);
        end
        next_cycle();
        EX_RegWrite = 1'b1; EX_WriteAddr = 5'd31;
        ID_Rs = 5'd31; ID_UsesRs = 1'b1; ID_JumpReg = 1'b1; ID_Jump = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_STALL) begin
            n_fails++; $display("FAIL jr_alu_ex_stall: got %b want %b", outs, O_STALL);
        end
        next_cycle();
        ID_JumpReg = 1'b0; ID_Jump = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_DEF) begin
            n_fails++; $display("FAIL alu_forwarded_no_stall: got %b want %b", outs, O_DEF);
        end
        next_cycle();
        clear_inputs();
        ID_Branch = 1'b1; BranchTaken = 1'b0; ID_Rs = 5'd4; ID_UsesRs = 1'b1;
        MEM_MemRead = 1'b0; MEM_WriteAddr = 5'd4;
        @(negedge clk);
        n_checks++;
        if (outs !== O_DEF) begin
            n_fails++; $display("FAIL beq_not_taken: got %b want %b", outs, O_DEF);
        end
        next_cycle();
    endtask

    task automatic test_zero_and_jump();
        clear_inputs();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteAddr = 5'd0;
        ID_UsesRs = 1'b1; ID_UsesRt = 1'b1; ID_Branch = 1'b1;
        MEM_MemRead = 1'b1; MEM_WriteAddr = 5'd0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_DEF) begin
            n_fails++; $display("FAIL zero_reg_no_stall: got %b want %b", outs, O_DEF);
        end
        next_cycle();
        clear_inputs();
        ID_Jump = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_REDIR) begin
            n_fails++; $display("FAIL jal_redirect: got %b want %b", outs, O_REDIR);
        end
        next_cycle();
        ID_Jump = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_DEF) begin
            n_fails++; $display("FAIL jal_flush_one_cycle: got %b want %b", outs, O_DEF);
        end
        next_cycle();
    endtask

    task automatic test_mul_hold();
        clear_inputs();
        EX_MulStart = 1'b1;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteAddr = 5'd8;
        ID_Rs = 5'd8; ID_UsesRs = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ID_Jump = (c == 1);
            @(negedge clk);
            n_checks++;
            if (outs !== O_MUL) begin
                n_fails++; $display("FAIL mul_hold_c%0d: got %b want %b", c, outs, O_MUL);
            end
            next_cycle();
        end
        ID_Jump = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== O_STALL) begin
            n_fails++; $display("FAIL mul_release_hazard: got %b want %b", outs, O_STALL);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== O_DEF) begin
            n_fails++; $display("FAIL mul_after_release: got %b want %b", outs, O_DEF);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_mul();
        clear_inputs();
        EX_MulStart = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_MUL) begin
            n_fails++; $display("FAIL rmul_start: got %b want %b", outs, O_MUL);
        end
        next_cycle();
        EX_MulStart = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== O_RST) begin
            n_fails++; $display("FAIL rmul_reset_outputs: got %b want %b", outs, O_RST);
        end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== O_DEF) begin
                n_fails++; $display("FAIL rmul_aborted_c%0d: got %b want %b", c, outs, O_DEF);
            end
            next_cycle();
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteAddr = 5'd8;
        ID_Rs = 5'd8; ID_UsesRs = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();
        EX_MulStart = 1'b1;
        for (int c = 0; c < 4; c++) next_cycle();
        clear_inputs();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (Stall_Cycles !== 32'd1) begin
            n_fails++; $display("FAIL perf_stall: got %0d want 1", Stall_Cycles);
        end
        n_checks++;
        if (MulHold_Cycles !== 32'd3) begin
            n_fails++; $display("FAIL perf_mulhold: got %0d want 3", MulHold_Cycles);
        end
        n_checks++;
        if (Flush_Count !== 32'd0) begin
            n_fails++; $display("FAIL perf_flush: got %0d want 0", Flush_Count);
        end
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch_after_load();
        test_zero_and_jump();
        test_mul_hold();
        test_reset_mid_mul();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
